mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle multiply/divide engine serving the RV32M datapath. It executes ops issued by the
//  instruction decoder via Start/MCycleOp (00 signed mul, 01 unsigned mul, 10 signed div,
//  11 unsigned div) and returns results selected into the compute result when MulDiv is set.
//  The pipeline stalls on Busy. Iterative: one partial product or quotient bit per cycle.
// PARAMETERS
//  WIDTH   32   operand width in bits; products are 2*WIDTH bits.
// PORTS
//  CLK        in   1      clock, rising edge
//  RESETn     in   1      asynchronous, active-low reset
//  Start      in   1      level request from decoder; sampled only in IDLE
//  MCycleOp   in   2      [1]=div/mul, [0]=unsigned/signed; latched with Start
//  Operand1   in   WIDTH  multiplicand / dividend; latched with Start
//  Operand2   in   WIDTH  multiplier / divisor; latched with Start
//  Result1    out  WIDTH  mul: product[WIDTH-1:0]; div: quotient
//  Result2    out  WIDTH  mul: product[2W-1:WIDTH]; div: remainder
//  Busy       out  1      high while the op is in COMPUTE (pipeline stall)
//  Done       out  1      one-cycle pulse; results valid from this cycle
// BEHAVIOUR
//  Interface: one clock (CLK); reset RESETn is asynchronous and active-low.
//  Reset (async, any state, incl. mid-op): state=IDLE, count=0, Result1=Result2=0, Busy=0, Done=0.
//  FSM: IDLE -(Start)-> COMPUTE -(count==WIDTH-1)-> DONE -> IDLE (unconditional).
//  Latency: Start high in IDLE at cycle 0 -> Busy high cycles 1..WIDTH -> Done=1, Busy=0
//   at cycle WIDTH+1; results registered at that edge. WIDTH=32: Done at cycle 33.
//  Start while COMPUTE or DONE is ignored. Start still high on the IDLE cycle after DONE
//   begins a new op; the issuing stage must have advanced or dropped Start by then.
//  Operands and op are captured at the Start edge. Later input changes do not affect the op.
//  Result1/Result2 hold their last value until the next Done. They are not cleared on Start.
//  Signed ops: take magnitudes at capture and record the sign flags.
//   Product is negated if the operand signs differ.
//   Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
//  Multiply: shift-add over WIDTH iterations. Accumulator is 2*WIDTH+1 bits so no carry is lost.
//  Divide: restoring, one quotient bit per iteration. Partial remainder is WIDTH+1 bits.
//  Divide-by-zero (Operand2==0): Result1 = all ones, Result2 = Operand1 (RISC-V semantics).
//   Applies to signed and unsigned divide.
//  Signed overflow (Operand1 = 1<<(WIDTH-1), Operand2 = -1): Result1 = Operand1, Result2 = 0.
//  Special cases keep the full WIDTH+1 latency; timing depends only on Start.
//  Counter: log2(WIDTH) bits; cleared on Start and on reset. No wrap is visible outside.
// TESTING
//  1. Unsigned mul: Op=01, 0xFFFFFFFF * 0xFFFFFFFF -> Result2=0xFFFFFFFE,
//     Result1=0x00000001, Done at cycle 33.
//  2. Signed mul: Op=00, -3 * 7 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB;
//     0x80000000 * 0x80000000 -> Result2=0x40000000, Result1=0.
//  3. Div: Op=10, -7 / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF;
//     Op=11, 100 / 7 -> Result1=14, Result2=2.
//  4. Corners: Op=11, 5 / 0 -> Result1=0xFFFFFFFF, Result2=5;
//     Op=10, 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0.
//  5. Start held through the op, with Operand1 changed at cycle 10 -> result uses the captured
//     value. Busy never re-rises before Done. Back-to-back op starts at cycle 34.
//  6. RESETn low at cycle 15 of a divide -> Busy=Done=0, results=0 immediately;
//     next Start gives a correct result at full latency.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the RV32M decoder and the mul/div engine.
// Ports: Start, MCycleOp, Operand1, Operand2 (decoder->unit); Result1, Result2, Busy, Done (unit->decoder).
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide engine: one product or quotient bit per cycle.
// Ports: CLK, RESETn (async active-low), bus (slave side of mul_div_unit_if).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           CLK,
    input logic           RESETn,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] b_reg;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] res1;
    logic [WIDTH-1:0] res2;
    logic             busy;
    logic             done;

    // Operand magnitudes and sign flags at capture time.
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        signed_op = ~bus.MCycleOp[0];
        a_neg     = signed_op & bus.Operand1[WIDTH-1];
        b_neg     = signed_op & bus.Operand2[WIDTH-1];
        a_mag     = a_neg ? -bus.Operand1 : bus.Operand1;
        b_mag     = b_neg ? -bus.Operand2 : bus.Operand2;
    end

    // One iteration of each algorithm.
    // Multiply: acc = {carry, high, multiplier}; add on LSB then shift right.
    // Divide:   acc = {partial remainder (W+1), dividend/quotient (W)}.
    logic [WIDTH:0]     add_term;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   mul_next;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH:0]   div_next;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        add_term = acc[0] ? {1'b0, b_reg} : '0;
        sum      = acc[2*WIDTH:WIDTH] + add_term;
        mul_next = {1'b0, sum, acc[WIDTH-1:1]};

        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, b_reg};
        if (diff[WIDTH+1]) begin
            div_next = {shifted, acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
        end

        prod     = mul_next[2*WIDTH-1:0];
        prod_fix = neg_res ? -prod : prod;

        // Divide-by-zero naturally yields all-ones quotient and the dividend
        // as remainder; only the sign fixup of the quotient must be bypassed.
        // Signed overflow falls out of the magnitude arithmetic unaided.
        quo      = div_next[WIDTH-1:0];
        rem      = div_next[2*WIDTH-1:WIDTH];
        quo_fix  = div_zero ? '1 : (neg_res ? -quo : quo);
        rem_fix  = neg_rem ? -rem : rem;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            b_reg    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            res1     <= '0;
            res2     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state    <= COMPUTE;
                        busy     <= 1'b1;
                        count    <= '0;
                        is_div   <= bus.MCycleOp[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= bus.MCycleOp[1]
                                  & (bus.Operand2 == '0);
                        if (bus.MCycleOp[1]) begin
                            acc   <= {{(WIDTH+1){1'b0}}, a_mag};
                            b_reg <= b_mag;
                        end else begin
                            acc   <= {{(WIDTH+1){1'b0}}, b_mag};
                            b_reg <= a_mag;
                        end
                    end
                end
                COMPUTE: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        res1  <= is_div ? quo_fix
                                        : prod_fix[WIDTH-1:0];
                        res2  <= is_div ? rem_fix
                                        : prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Result1 = res1;
    assign bus.Result2 = res2;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
endmodule
